// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the packed 11-bit command word
// carried through the command queue.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_PASS = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } alu_cmd_t;

    localparam int CMD_W = $bits(alu_cmd_t);

endpackage

// File: rtl/alu_cmd_fifo_mem.sv
// Command storage for alu_cmd_queue: DEPTH entries, one synchronous write port
// and a combinational read at the read pointer.
module alu_cmd_fifo_mem
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_ptr,
    input  logic [CMD_W-1:0] wr_data,
    input  logic [AW-1:0]    rd_ptr,
    output logic [CMD_W-1:0] rd_data
);

    // Storage is not reset; validity is tracked by the queue's count.
    logic [CMD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/alu_cmd_queue.sv
// FIFO of ALU commands feeding a registered a/b/op issue stage.
// Optional macro ALU_CMD_QUEUE_BYPASS_EN lets a push into an empty queue issue on the same edge.
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_a,
    input  logic [3:0]             in_b,
    input  logic [2:0]             in_op,
    input  logic                   alu_ready,
    output logic [3:0]             a,
    output logic [3:0]             b,
    output logic [2:0]             op,
    output logic                   issue_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             bypass;
    logic             store;
    alu_cmd_t         in_cmd;
    alu_cmd_t         rd_cmd;
    logic [CMD_W-1:0] rd_data;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;

    assign in_cmd = '{a: in_a, b: in_b, op: in_op};
    assign rd_cmd = alu_cmd_t'(rd_data);

    assign push = in_valid && in_ready;
    assign pop  = !empty && alu_ready;

`ifdef ALU_CMD_QUEUE_BYPASS_EN
    // An empty queue with a willing ALU hands the command straight to the issue registers.
    assign bypass = push && empty && alu_ready;
`else
    assign bypass = 1'b0;
`endif

    assign store = push && !bypass;

    alu_cmd_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (store),
        .wr_ptr  (wr_ptr),
        .wr_data (in_cmd),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            a           <= '0;
            b           <= '0;
            op          <= '0;
            issue_valid <= 1'b0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({store, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            issue_valid <= pop || bypass;
            if (pop) begin
                a  <= rd_cmd.a;
                b  <= rd_cmd.b;
                op <= rd_cmd.op;
            end else if (bypass) begin
                a  <= in_a;
                b  <= in_b;
                op <= in_op;
            end
        end
    end

endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of command entries; power of two, at least 2.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  producer presents a command.
REQ-005 SHALL have port: in_ready  output  1  queue can accept; equals !full.
REQ-006 SHALL have ports: in_a  input  4, in_b  input  4, in_op  input  3  command operands and opcode.
REQ-007 SHALL have port: alu_ready  input  1  downstream ALU stage permits an issue this cycle.
REQ-008 SHALL have ports: a  output  4, b  output  4, op  output  3  registered command driving the ALU.
REQ-009 SHALL have port: issue_valid  output  1  registered; high for exactly the cycle after each issue.
REQ-010 SHALL have port: count  output  $clog2(DEPTH)+1  current number of stored entries.
REQ-011 SHALL have ports: full  output  1, empty  output  1  combinational from count.

Function
REQ-012 SHALL accept a command (push) on a posedge where in_valid && in_ready.
REQ-013 SHALL pop the oldest entry on a posedge where !empty && alu_ready, loading it into a/b/op and setting issue_valid=1.
REQ-014 SHALL clear issue_valid to 0 on every posedge without a pop; a/b/op SHALL then hold their last values.
REQ-015 SHALL issue commands in strict FIFO order with no loss or duplication.
REQ-016 SHALL have a latency of one edge: a command pushed at edge k has issue_valid=1 after edge k+1 at the earliest.
REQ-017 SHALL push and pop on the same edge when both conditions hold; count SHALL be unchanged.
REQ-018 SHALL hold in_ready=0 when count==DEPTH; a pop while full frees a slot, and in_ready SHALL be 1 after that edge.
REQ-019 SHALL never pop when empty; alu_ready while empty SHALL produce issue_valid=0.
REQ-020 SHALL wrap read and write pointers modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-021 SHALL keep a/b/op/issue_valid stable, changing only on posedge clk.

Reset
REQ-022 SHALL, when rst is high, immediately set a=0, b=0, op=0, issue_valid=0, pointers=0 and count=0 (empty=1, full=0, in_ready=1).
REQ-023 SHALL discard all queued commands when rst is asserted mid-operation; no command accepted before reset is issued afterwards.
REQ-024 SHALL perform no push or pop while rst is high.

Configuration
REQ-025 SHALL support macro ALU_CMD_QUEUE_BYPASS_EN.
REQ-026 SHALL, with ALU_CMD_QUEUE_BYPASS_EN defined, load a pushed command directly into a/b/op with issue_valid=1 at the same edge when empty && alu_ready; the command is not stored and count stays 0.
REQ-027 SHALL, without the macro, always store a pushed command first, giving the REQ-016 latency in all cases.

Structure
REQ-028 SHALL take the opcode constants (ADD=000, SUB=001, AND=010, OR=011, XOR=100, SHL=101, SHR=110, PASS=111) and an 11-bit packed command typedef {a,b,op} from the shared package alu_pkg.
REQ-029 SHALL implement storage as one sub-module, alu_cmd_fifo_mem: DEPTH x 11-bit register array with write port and combinational read at the read pointer.

Verification
REQ-030 SHALL cover reset: assert rst mid-stream with 3 entries queued -> count=0, issue_valid=0, a/b/op=0 immediately; no stale issue after release.
REQ-031 SHALL cover ordering: push {3,5,ADD},{9,2,SUB},{6,6,XOR} with alu_ready=1 -> issues appear in that order on consecutive cycles, one edge after each push.
REQ-032 SHALL cover full: alu_ready=0, push 5 commands with DEPTH=4 -> first 4 accepted, count=4, full=1, in_ready=0, 5th held; raise alu_ready -> 5th accepted one edge later.
REQ-033 SHALL cover simultaneous push/pop at count=2 -> count remains 2, issued entry is the oldest.
REQ-034 SHALL cover stall: count=1, alu_ready=0 for 3 cycles -> issue_valid=0, a/b/op hold; alu_ready=1 -> single issue, count=0, empty=1.
REQ-035 SHALL cover bypass: with ALU_CMD_QUEUE_BYPASS_EN, empty queue, push {4,1,SHL} with alu_ready=1 -> a=4, b=1, op=101, issue_valid=1 after the same edge, count=0; without the macro -> issue one edge later.
